// File: rtl/mem_stage.sv
// Memory stage of the 5-stage RISC-V pipeline: EX/MEM and MEM/WB registers,
// request/ready data-memory port with byte enables, load extension and write-back select.
module mem_stage #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALUResult_ex,
  input  logic [31:0] MemWriteData_ex,
  input  logic [4:0]  rdAddr_ex,
  input  logic        RegWrite_ex,
  input  logic        MemRead_ex,
  input  logic        MemWrite_ex,
  input  logic        MemtoReg_ex,
  input  logic [2:0]  funct3_ex,
  output logic [31:0] ALUResult_mem,
  output logic [4:0]  rdAddr_mem,
  output logic        RegWrite_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic [31:0] RegWriteData_wb,
  output logic [4:0]  rdAddr_wb,
  output logic        RegWrite_wb,
  output logic        misaligned,
  output logic        bus_err
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam logic [8:0] LAST_IDX = 9'(TIMEOUT - 1);

  // EX/MEM pipeline register
  logic [31:0] r_alu;
  logic [31:0] r_wdata;
  logic [4:0]  r_rd;
  logic        r_regwrite;
  logic        r_memread;
  logic        r_memwrite;
  logic        r_memtoreg;
  logic [2:0]  r_funct3;

  // MEM/WB pipeline register
  logic [31:0] r_wb_data;
  logic [4:0]  r_wb_rd;
  logic        r_wb_we;

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_wcnt;
  logic [7:0]  w_wcnt_next;

  logic [1:0]  w_size;
  logic        w_memop;
  logic        w_misalign_cond;
  logic        w_misalign;
  logic        w_acc;
  logic [8:0]  w_wait_idx;
  logic        w_abort;
  logic        w_stall;
  logic        w_rd_valid;
  logic [31:0] w_store_data;
  logic [3:0]  w_store_be;
  logic [7:0]  w_lbyte;
  logic [15:0] w_lhalf;
  logic [31:0] w_load_ext;
  logic [31:0] w_load_data;

  assign w_size          = r_funct3[1:0];
  assign w_memop         = r_memread | r_memwrite;
  assign w_misalign_cond = ((w_size == 2'b01) & r_alu[0]) |
                           ((w_size == 2'b10) & (r_alu[1:0] != 2'b00));
  assign w_misalign      = w_memop & w_misalign_cond;
  assign w_acc           = w_memop & ~w_misalign_cond;

  // Index of the current cycle within the access: the first (IDLE) cycle is 0,
  // so the abort lands on cycle TIMEOUT-1 after TIMEOUT-1 stall cycles.
  assign w_wait_idx = (r_state == S_WAIT) ? ({1'b0, r_wcnt} + 9'd1) : 9'd0;
  assign w_abort    = w_acc & ~dmem_ready & (w_wait_idx == LAST_IDX);
  assign w_stall    = w_acc & ~dmem_ready & ~w_abort;
  assign w_rd_valid = w_acc & dmem_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_alu      <= '0;
      r_wdata    <= '0;
      r_rd       <= '0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_funct3   <= '0;
    end else if (!w_stall) begin
      r_alu      <= ALUResult_ex;
      r_wdata    <= MemWriteData_ex;
      r_rd       <= rdAddr_ex;
      r_regwrite <= RegWrite_ex;
      r_memread  <= MemRead_ex;
      r_memwrite <= MemWrite_ex;
      r_memtoreg <= MemtoReg_ex;
      r_funct3   <= funct3_ex;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_state_next;
      r_wcnt  <= w_wcnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_wcnt_next  = r_wcnt;
    case (r_state)
      S_IDLE: begin
        if (w_stall) begin
          w_state_next = S_WAIT;
          w_wcnt_next  = '0;
        end
      end
      S_WAIT: begin
        if (w_stall) begin
          w_wcnt_next = r_wcnt + 8'd1;
        end else begin
          w_state_next = S_IDLE;
          w_wcnt_next  = '0;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_wcnt_next  = '0;
      end
    endcase
  end

  always_comb begin
    w_store_data = r_wdata;
    w_store_be   = 4'b1111;
    case (w_size)
      2'b00: begin
        w_store_data = {4{r_wdata[7:0]}};
        w_store_be   = 4'b0001 << r_alu[1:0];
      end
      2'b01: begin
        w_store_data = {2{r_wdata[15:0]}};
        w_store_be   = r_alu[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        w_store_data = r_wdata;
        w_store_be   = 4'b1111;
      end
    endcase
  end

  always_comb begin
    w_lbyte = dmem_rdata[7:0];
    case (r_alu[1:0])
      2'b00:   w_lbyte = dmem_rdata[7:0];
      2'b01:   w_lbyte = dmem_rdata[15:8];
      2'b10:   w_lbyte = dmem_rdata[23:16];
      default: w_lbyte = dmem_rdata[31:24];
    endcase
    w_lhalf = r_alu[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    w_load_ext = dmem_rdata;
    case (r_funct3)
      3'b000:  w_load_ext = {{24{w_lbyte[7]}}, w_lbyte};
      3'b100:  w_load_ext = {24'd0, w_lbyte};
      3'b001:  w_load_ext = {{16{w_lhalf[15]}}, w_lhalf};
      3'b101:  w_load_ext = {16'd0, w_lhalf};
      default: w_load_ext = dmem_rdata;
    endcase
  end

  // Read data is only trusted in the cycle the memory answers our own request.
  assign w_load_data = w_rd_valid ? w_load_ext : 32'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wb_data <= '0;
      r_wb_rd   <= '0;
      r_wb_we   <= 1'b0;
    end else if (w_stall) begin
      r_wb_data <= '0;
      r_wb_rd   <= '0;
      r_wb_we   <= 1'b0;
    end else begin
      r_wb_data <= r_memtoreg ? w_load_data : r_alu;
      r_wb_rd   <= r_rd;
      r_wb_we   <= r_regwrite & ~w_misalign & ~w_abort;
    end
  end

  assign ALUResult_mem   = r_alu;
  assign rdAddr_mem      = r_rd;
  assign RegWrite_mem    = r_regwrite;
  assign dmem_req        = w_acc;
  assign dmem_we         = r_memwrite;
  assign dmem_addr       = {r_alu[31:2], 2'b00};
  assign dmem_wdata      = w_store_data;
  assign dmem_be         = r_memwrite ? w_store_be : 4'b1111;
  assign mem_stall       = w_stall;
  assign RegWriteData_wb = r_wb_data;
  assign rdAddr_wb       = r_wb_rd;
  assign RegWrite_wb     = r_wb_we;
  assign misaligned      = w_misalign;
  assign bus_err         = w_abort;

endmodule
